// File: rtl/ucsbece154_icache.sv
// ============================================================================
// ucsbece154_icache: direct-mapped I-cache with a critical-word-first refill
// engine. Revision: 1.0
// ============================================================================
`default_nettype none

module ucsbece154_icache #(
  parameter int NUM_SETS    = 8,
  parameter int BLOCK_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReadEnable,
  input  logic [31:0] PCF,
  output logic [31:0] Instr,
  output logic        Stall,
  output logic        ReadRequest,
  output logic [31:0] ReadAddress,
  input  logic [31:0] DataIn,
  input  logic        DataReady
);

  localparam int LOGB = $clog2(BLOCK_WORDS);
  localparam int LOGS = $clog2(NUM_SETS);
  localparam int TAGW = 32 - LOGB - LOGS - 2;
  localparam logic [LOGB:0]   CNT_FULL = BLOCK_WORDS[LOGB:0];
  localparam logic [LOGB:0]   CNT_ONE  = 1;
  localparam logic [LOGB-1:0] PTR_ONE  = 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_REFILL = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [31:0]   miss_addr_q, miss_addr_d;
  logic [LOGB:0] ptr_q, ptr_d;
  logic [LOGB:0] cnt_q, cnt_d;

  logic [TAGW-1:0]        tag_q   [NUM_SETS];
  logic [31:0]            data_q  [NUM_SETS][BLOCK_WORDS];
  logic [BLOCK_WORDS-1:0] valid_q [NUM_SETS];

  logic [LOGB-1:0] w_wi;
  logic [LOGS-1:0] w_si;
  logic [TAGW-1:0] w_tag;
  logic [LOGS-1:0] w_miss_si;
  logic [LOGB-1:0] w_ptr_lo;
  logic [29:0]     w_fill_word;
  logic            w_hit, w_fill, w_fwd, w_miss_go;
  logic            w_unused;

  assign w_wi      = PCF[LOGB+1:2];
  assign w_si      = PCF[LOGB+LOGS+1:LOGB+2];
  assign w_tag     = PCF[31:LOGB+LOGS+2];
  assign w_miss_si = miss_addr_q[LOGB+LOGS+1:LOGB+2];
  assign w_ptr_lo  = ptr_q[LOGB-1:0];
  assign w_unused  = &{1'b0, PCF[1:0], ptr_q[LOGB]};

  assign w_hit  = valid_q[w_si][w_wi] && (tag_q[w_si] == w_tag);
  assign w_fill = (state_q != S_IDLE) && DataReady;

  // Word address of the beat being written this cycle; a fetch of exactly
  // that word is served straight from DataIn.
  assign w_fill_word = {miss_addr_q[31:LOGB+2], w_ptr_lo};
  assign w_fwd       = w_fill && (PCF[31:2] == w_fill_word);

  assign ReadRequest = (state_q == S_REQ);
  assign ReadAddress = miss_addr_q;

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    w_miss_go   = 1'b0;
    Instr       = '0;
    Stall       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ReadEnable) begin
          if (w_hit) begin
            Instr = data_q[w_si][w_wi];
          end else begin
            Stall       = 1'b1;
            w_miss_go   = 1'b1;
            miss_addr_d = {PCF[31:2], 2'b00};
            ptr_d       = {1'b0, w_wi};
            cnt_d       = '0;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ, S_REFILL: begin
        Stall = 1'b1;
        if (ReadEnable && w_fwd) begin
          Instr = DataIn;
          Stall = 1'b0;
        end else if (ReadEnable && w_hit) begin
          Instr = data_q[w_si][w_wi];
          Stall = 1'b0;
        end
        if (state_q == S_REQ) begin
          if (DataReady) begin
            ptr_d   = {1'b0, w_ptr_lo + PTR_ONE};
            cnt_d   = CNT_ONE;
            state_d = S_REFILL;
          end
        end else if (DataReady) begin
          ptr_d = {1'b0, w_ptr_lo + PTR_ONE};
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_d == CNT_FULL) state_d = S_IDLE;
        end else begin
          // A short burst ends the refill; unreceived words stay invalid.
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!reset) begin
      Instr = '0;
      Stall = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      miss_addr_q <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      if (w_miss_go) valid_q[w_si] <= '0;
      if (w_fill)    valid_q[w_miss_si][w_ptr_lo] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (w_miss_go) tag_q[w_si] <= w_tag;
    if (w_fill)    data_q[w_miss_si][w_ptr_lo] <= DataIn;
  end

endmodule

`default_nettype wire

// File: tb/tb_ucsbece154_icache.sv
// ============================================================================
// tb_ucsbece154_icache: directed self-checking bench for the instruction cache.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ucsbece154_icache;

  logic        clk = 1'b0;
  logic        reset;
  logic        ReadEnable;
  logic [31:0] PCF;
  logic [31:0] Instr;
  logic        Stall;
  logic        ReadRequest;
  logic [31:0] ReadAddress;
  logic [31:0] DataIn;
  logic        DataReady;

  int n_cmp = 0;
  int n_err = 0;

  ucsbece154_icache #(.NUM_SETS(8), .BLOCK_WORDS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .ReadEnable  (ReadEnable),
    .PCF         (PCF),
    .Instr       (Instr),
    .Stall       (Stall),
    .ReadRequest (ReadRequest),
    .ReadAddress (ReadAddress),
    .DataIn      (DataIn),
    .DataReady   (DataReady)
  );

  always #5 clk = ~clk;

  // Memory contents: each word encodes its own address.
  function automatic logic [31:0] txt(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic re, input logic [31:0] pc, input logic dr, input logic [31:0] di);
    ReadEnable = re;
    PCF        = pc;
    DataReady  = dr;
    DataIn     = di;
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] instr_e, input logic stall_e, input logic rr_e);
    chk({tag, ".stall"}, {31'b0, Stall}, {31'b0, stall_e});
    chk({tag, ".rreq"}, {31'b0, ReadRequest}, {31'b0, rr_e});
    if (!stall_e) chk({tag, ".instr"}, Instr, instr_e);
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    look("reset", 32'h0, 1'b0, 1'b0);
    chk("reset.raddr", ReadAddress, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Cold miss on word 2, critical word first.
    drive(1'b1, 32'h00010008, 1'b0, 32'h0);
    look("cold_miss", 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      drive(1'b1, 32'h00010008, 1'b0, 32'h0);
      look("req_wait", 32'h0, 1'b1, 1'b1);
      chk("req_wait.raddr", ReadAddress, 32'h00010008);
    end
    cyc();
    drive(1'b1, 32'h00010008, 1'b1, txt(32'h00010008));
    look("crit_fwd", txt(32'h00010008), 1'b0, 1'b1);
    cyc();
    drive(1'b1, 32'h0001000C, 1'b1, txt(32'h0001000C));
    look("tail_fwd", txt(32'h0001000C), 1'b0, 1'b0);
    chk("tail_fwd.raddr", ReadAddress, 32'h00010008);
    cyc();
    drive(1'b1, 32'h00010008, 1'b1, txt(32'h00010000));
    look("refill_hit", txt(32'h00010008), 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'h00010008, 1'b1, txt(32'h00010004));
    look("refill_hit2", txt(32'h00010008), 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'h00010000, 1'b0, 32'h0);
    look("hit_w0", txt(32'h00010000), 1'b0, 1'b0);
    drive(1'b1, 32'h00010004, 1'b0, 32'h0);
    look("hit_w1", txt(32'h00010004), 1'b0, 1'b0);
    drive(1'b1, 32'h0001000C, 1'b0, 32'h0);
    look("hit_w3", txt(32'h0001000C), 1'b0, 1'b0);

    // Short burst: only words 2 and 3 arrive.
    cyc();
    drive(1'b1, 32'h00020018, 1'b0, 32'h0);
    look("sb_miss", 32'h0, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 32'h00020018, 1'b1, txt(32'h00020018));
    look("sb_crit", txt(32'h00020018), 1'b0, 1'b1);
    chk("sb_crit.raddr", ReadAddress, 32'h00020018);
    cyc();
    drive(1'b1, 32'h0002001C, 1'b1, txt(32'h0002001C));
    look("sb_tail", txt(32'h0002001C), 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'h00020010, 1'b0, 32'h0);
    look("sb_gap", 32'h0, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 32'h00020010, 1'b0, 32'h0);
    look("sb_remiss", 32'h0, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 32'h00020010, 1'b0, 32'h0);
    look("sb_req", 32'h0, 1'b1, 1'b1);
    chk("sb_req.raddr", ReadAddress, 32'h00020010);
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive(1'b1, 32'h00020010, 1'b1, txt(32'h00020010 + 32'(4 * i)));
    end
    cyc();
    drive(1'b1, 32'h00020014, 1'b0, 32'h0);
    look("sb_full", txt(32'h00020014), 1'b0, 1'b0);
    drive(1'b1, 32'h00010000, 1'b0, 32'h0);
    look("set0_kept", txt(32'h00010000), 1'b0, 1'b0);

    // Conflict eviction in set 0.
    drive(1'b1, 32'h00010080, 1'b0, 32'h0);
    look("cf_miss", 32'h0, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 32'h00010080, 1'b0, 32'h0);
    look("cf_req", 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive(1'b1, 32'h00010080, 1'b1, txt(32'h00010080 + 32'(4 * i)));
    end
    cyc();
    drive(1'b1, 32'h00010080, 1'b0, 32'h0);
    look("cf_hit", txt(32'h00010080), 1'b0, 1'b0);
    drive(1'b1, 32'h00010000, 1'b0, 32'h0);
    look("cf_evict", 32'h0, 1'b1, 1'b0);

    // Refill of 0x00010000 while fetch asks for an unrelated missing line.
    cyc();
    drive(1'b1, 32'h00010040, 1'b1, txt(32'h00010000));
    look("om_req", 32'h0, 1'b1, 1'b1);
    chk("om_req.raddr", ReadAddress, 32'h00010000);
    for (int i = 1; i < 4; i++) begin
      cyc();
      drive(1'b1, 32'h00010040, 1'b1, txt(32'h00010000 + 32'(4 * i)));
      look("om_refill", 32'h0, 1'b1, 1'b0);
    end
    cyc();
    drive(1'b1, 32'h00010040, 1'b0, 32'h0);
    look("om_idle", 32'h0, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 32'h00010040, 1'b0, 32'h0);
    look("om_newreq", 32'h0, 1'b1, 1'b1);
    chk("om_newreq.raddr", ReadAddress, 32'h00010040);
    drive(1'b1, 32'h00010004, 1'b0, 32'h0);
    look("busy_hit", txt(32'h00010004), 1'b0, 1'b1);

    // Reset in the middle of a pending request.
    drive(1'b1, 32'h00010040, 1'b0, 32'h0);
    repeat (3) cyc();
    reset = 1'b0;
    #1;
    look("rst_mid", 32'h0, 1'b0, 1'b0);
    chk("rst_mid.raddr", ReadAddress, 32'h0);
    cyc();
    cyc();
    reset = 1'b1;
    drive(1'b1, 32'h00010008, 1'b0, 32'h0);
    look("post_rst_miss", 32'h0, 1'b1, 1'b0);
    drive(1'b1, 32'h00010000, 1'b0, 32'h0);
    look("post_rst_w0", 32'h0, 1'b1, 1'b0);
    drive(1'b1, 32'h00010008, 1'b0, 32'h0);
    cyc();
    drive(1'b1, 32'h00010008, 1'b0, 32'h0);
    look("post_rst_req", 32'h0, 1'b1, 1'b1);
    chk("post_rst_req.raddr", ReadAddress, 32'h00010008);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
